// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 stream multiplexer: default sizes,
// a clog2 helper and the beat type held in the output register.
package mux_pkg;

  localparam int N_IN_DEF  = 16;
  localparam int WIDTH_DEF = 13;

  // Never returns less than 1, so a 2-input mux still gets a 1-bit select.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  localparam int SEL_W_DEF = clog2(N_IN_DEF);

  typedef struct packed {
    logic [WIDTH_DEF-1:0] data;
    logic [SEL_W_DEF-1:0] src;
  } beat_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: rotates the request vector so the channel
// after ptr sits at bit 0, then priority-encodes the lowest set bit.
module rr_priority_picker
  import mux_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int SEL_W = clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [N_IN-1:0] rotated;
  int              start;

  // ptr itself ends up in the top rotated position, so it is scanned last.
  always_comb begin
    start = int'(ptr) + 1;
    if (start >= N_IN) start = 0;
    rotated   = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N_IN; k++) begin
      rotated[k] = req[(start + k) % N_IN];
    end
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'((start + k) % N_IN);
      end
    end
  end

endmodule

// File: rtl/stream_mux_nx1.sv
// N-input, 1-output registered stream multiplexer with valid/ready handshake,
// selecting by fixed index or round-robin, with a one-deep output register.
module stream_mux_nx1
  import mux_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic                  rr_en,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_src
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             load;
  logic             transfer;

  rr_priority_picker #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_picker (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  assign load = !out_valid || out_ready;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (rr_en) begin
      grant       = rr_idx;
      grant_valid = rr_valid;
    end else if (int'(sel) < N_IN) begin
      grant       = sel;
      grant_valid = in_valid[sel];
    end
  end

  assign transfer = load && grant_valid;

  // Gated by rst_n so no channel sees a handshake while reset is held.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_ready[i] = rst_n && transfer && (int'(grant) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= SEL_W'(N_IN - 1);
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
      out_src   <= grant;
      rr_ptr    <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Directed self-checking bench for stream_mux_nx1 at its default size
// (16 channels, 13-bit data); outputs are sampled on the falling edge.
module tb_stream_mux_nx1;
  import mux_pkg::*;

  localparam int N_IN  = 16;
  localparam int WIDTH = 13;
  localparam int SEL_W = 4;

  logic                  clk;
  logic                  rst_n;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic                  rr_en;
  logic [SEL_W-1:0]      sel;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SEL_W-1:0]      out_src;

  int    checks;
  int    errors;
  beat_t exp_beat;

  stream_mux_nx1 #(
    .N_IN  (N_IN),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_en     (rr_en),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected) else begin
      errors = errors + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_beat(input string tag, input beat_t exp);
    check_output({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_output({tag, "_src"},   32'(out_src),   32'(exp.src));
    check_output({tag, "_data"},  32'(out_data),  32'(exp.data));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    rr_en     = 1'b1;
    sel       = '0;
    out_ready = 1'b1;
    in_valid  = '1;
    in_data   = '0;
    for (int i = 0; i < N_IN; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(i);

    // Reset held with every channel valid: nothing may be accepted or shown.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output("rst_out_valid", 32'(out_valid), 32'd0);
      check_output("rst_out_data",  32'(out_data),  32'd0);
      check_output("rst_out_src",   32'(out_src),   32'd0);
      check_output("rst_in_ready",  32'(in_ready),  32'd0);
    end
    in_valid = '0;
    rst_n    = 1'b1;

    // Fixed select of channel 3.
    @(negedge clk);
    rr_en    = 1'b0;
    sel      = 4'd3;
    in_valid = 16'h0008;
    in_data[3*WIDTH +: WIDTH] = 13'h0ABC;
    #1;
    check_output("fix_in_ready", 32'(in_ready), 32'h0008);
    @(negedge clk);
    exp_beat.data = 13'h0ABC;
    exp_beat.src  = 4'd3;
    check_beat("fix_beat", exp_beat);

    // Fixed select of an idle channel while another is valid.
    sel      = 4'd5;
    in_valid = 16'h0004;
    #1;
    check_output("miss_in_ready", 32'(in_ready), 32'h0000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_output("miss_out_valid", 32'(out_valid), 32'd0);
      check_output("miss_in_ready_hold", 32'(in_ready), 32'h0000);
    end

    // Fresh reset so round-robin starts from the lowest index.
    in_valid = '0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N_IN; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(i);

    // Round-robin over all-valid channels: 0..15 then wrap to 0.
    rr_en    = 1'b1;
    in_valid = 16'hFFFF;
    for (int k = 0; k <= N_IN; k++) begin
      @(negedge clk);
      exp_beat.src  = SEL_W'(k % N_IN);
      exp_beat.data = WIDTH'(k % N_IN);
      check_beat("rr_beat", exp_beat);
    end

    // Backpressure on the src-0 beat just shown.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_output("bp_in_ready", 32'(in_ready), 32'h0000);
      @(negedge clk);
      exp_beat.src  = 4'd0;
      exp_beat.data = 13'd0;
      check_beat("bp_hold", exp_beat);
    end
    out_ready = 1'b1;
    #1;
    check_output("bp_release_in_ready", 32'(in_ready), 32'h0002);
    @(negedge clk);
    exp_beat.src  = 4'd1;
    exp_beat.data = 13'd1;
    check_beat("bp_release", exp_beat);

    // Continue to src 9, then reset mid-stream.
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      exp_beat.src  = SEL_W'(k);
      exp_beat.data = WIDTH'(k);
      check_beat("pre_rst_beat", exp_beat);
    end
    rst_n = 1'b0;
    #1;
    check_output("midrst_out_valid", 32'(out_valid), 32'd0);
    check_output("midrst_in_ready",  32'(in_ready),  32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_beat.src  = 4'd0;
    exp_beat.data = 13'd0;
    check_beat("post_rst_beat", exp_beat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
